// File: rtl/cond_logic_pkg.sv
// Shared definitions for the conditional-execution stage: condition codes
// and the bit positions of N, Z, C, V inside the flags nibble.
package cond_logic_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    localparam int N_IDX = 3;
    localparam int Z_IDX = 2;
    localparam int C_IDX = 1;
    localparam int V_IDX = 0;

endpackage

// File: rtl/cond_logic_if.sv
// Decoder/ALU side signals of the conditional-execution stage.
// The master drives the decoded request; the slave returns gated strobes.
interface cond_logic_if;
    logic       en;
    logic [3:0] cond;
    logic [3:0] alu_flags;
    logic [1:0] flag_w;
    logic       pcs;
    logic       reg_w;
    logic       mem_w;
    logic       no_write;
    logic       cond_ex;
    logic       pc_src;
    logic       reg_write;
    logic       mem_write;
    logic [3:0] flags;

    modport master (
        output en, cond, alu_flags, flag_w, pcs, reg_w, mem_w, no_write,
        input  cond_ex, pc_src, reg_write, mem_write, flags
    );

    modport slave (
        input  en, cond, alu_flags, flag_w, pcs, reg_w, mem_w, no_write,
        output cond_ex, pc_src, reg_write, mem_write, flags
    );
endinterface

// File: rtl/cond_logic_condcheck.sv
// Purely combinational evaluation of an instruction condition field
// against the stored {N,Z,C,V} flags.
module condcheck
    import cond_logic_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);
    logic n_s, z_s, c_s, v_s;

    assign n_s = flags[N_IDX];
    assign z_s = flags[Z_IDX];
    assign c_s = flags[C_IDX];
    assign v_s = flags[V_IDX];

    // Condition table; NV is treated as always-pass, never as a trap.
    always_comb begin
        cond_ex = 1'b1;
        case (cond_e'(cond))
            COND_EQ: cond_ex = z_s;
            COND_NE: cond_ex = ~z_s;
            COND_CS: cond_ex = c_s;
            COND_CC: cond_ex = ~c_s;
            COND_MI: cond_ex = n_s;
            COND_PL: cond_ex = ~n_s;
            COND_VS: cond_ex = v_s;
            COND_VC: cond_ex = ~v_s;
            COND_HI: cond_ex = c_s & ~z_s;
            COND_LS: cond_ex = ~c_s | z_s;
            COND_GE: cond_ex = (n_s == v_s);
            COND_LT: cond_ex = (n_s != v_s);
            COND_GT: cond_ex = ~z_s & (n_s == v_s);
            COND_LE: cond_ex = z_s | (n_s != v_s);
            COND_AL: cond_ex = 1'b1;
            COND_NV: cond_ex = 1'b1;
            default: cond_ex = 1'b1;
        endcase
    end
endmodule

// File: rtl/cond_logic.sv
// Conditional-execution stage: stored flags register, condition check and
// gating of the PC / register-file / memory write strobes.
module cond_logic
    import cond_logic_pkg::*;
#(
    parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
    input  logic         clk,
    input  logic         reset,
    cond_logic_if.slave  bus
);
    logic [3:0] flags_r;
    logic       cond_ex_s;
    logic       gate_s;
    logic       nz_we_s;
    logic       cv_we_s;

    condcheck u_condcheck (
        .cond    (bus.cond),
        .flags   (flags_r),
        .cond_ex (cond_ex_s)
    );

    // Reset is folded into the gate so no strobe can escape while it is held.
    assign gate_s  = cond_ex_s & bus.en & reset;
    assign nz_we_s = bus.flag_w[1] & gate_s;
    assign cv_we_s = bus.flag_w[0] & gate_s;

    // Flags register: N,Z and C,V halves load independently.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_r <= FLAGS_RESET;
        end else begin
            if (nz_we_s) begin
                flags_r[N_IDX:Z_IDX] <= bus.alu_flags[N_IDX:Z_IDX];
            end else begin
                flags_r[N_IDX:Z_IDX] <= flags_r[N_IDX:Z_IDX];
            end
            if (cv_we_s) begin
                flags_r[C_IDX:V_IDX] <= bus.alu_flags[C_IDX:V_IDX];
            end else begin
                flags_r[C_IDX:V_IDX] <= flags_r[C_IDX:V_IDX];
            end
        end
    end

    assign bus.cond_ex   = cond_ex_s;
    assign bus.pc_src    = bus.pcs & gate_s;
    assign bus.mem_write = bus.mem_w & gate_s;
    assign bus.reg_write = bus.reg_w & ~bus.no_write & gate_s;
    assign bus.flags     = flags_r;
endmodule

// File: doc/cond_logic.md
COND_LOGIC -- requirements
Module: cond_logic

Interface
REQ-001 Parameter FLAGS_RESET, default 4'b0000, SHALL set the reset value of the flags register in {N,Z,C,V} order.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  SHALL be asynchronous and active-low; the design uses one clock.
REQ-004 En  input  1  stage enable; 0 = stall; no state update; all write strobes forced 0.
REQ-005 Cond  input  4  instruction condition field, bits [31:28].
REQ-006 ALUFlags  input  4  {N,Z,C,V} from the ALU for the current instruction.
REQ-007 FlagW  input  2  bit1 = write N,Z; bit0 = write C,V (from decoder).
REQ-008 PCS  input  1  decoder request to write PC.
REQ-009 RegW  input  1  decoder request to write register file.
REQ-010 MemW  input  1  decoder request to write data memory.
REQ-011 NoWrite  input  1  compare-class op (CMP/CMN/TST/TEQ); suppresses register write.
REQ-012 CondEx  output  1  condition passed for the current instruction.
REQ-013 PCSrc  output  1  gated PC write.
REQ-014 RegWrite  output  1  gated register-file write.
REQ-015 MemWrite  output  1  gated memory write.
REQ-016 Flags  output  4  currently stored {N,Z,C,V}.

Function
REQ-017 CondEx SHALL be combinational from Cond and the stored Flags (not ALUFlags), evaluated as: 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C; 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V; 1000 HI C&~Z; 1001 LS ~C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 1.
REQ-018 PCSrc = PCS & CondEx & En; MemWrite = MemW & CondEx & En; RegWrite = RegW & CondEx & ~NoWrite & En; all combinational, zero latency.
REQ-019 Flags register SHALL split into two 2-bit halves: N,Z load ALUFlags[3:2] on a rising clk edge iff FlagW[1] & CondEx & En; C,V load ALUFlags[1:0] iff FlagW[0] & CondEx & En.
REQ-020 Each half not loaded SHALL hold its value; the halves update independently in the same edge.
REQ-021 An updated flag value SHALL be visible on Flags and in CondEx one cycle after the loading edge, never in the same cycle (an instruction never sees its own flags).
REQ-022 Failed condition (CondEx=0) SHALL suppress all strobes and both flag halves, regardless of FlagW.
REQ-023 En=0 SHALL freeze the flags register for that cycle; CondEx still reflects the stored flags.
REQ-024 Cond=1111 SHALL be treated as always-pass; no error or trap is generated.

Reset
REQ-025 reset low SHALL asynchronously set Flags to FLAGS_RESET, independent of clk.
REQ-026 While reset is low, PCSrc, RegWrite and MemWrite SHALL be 0; CondEx follows REQ-017 on FLAGS_RESET.
REQ-027 Reset deasserting mid-operation SHALL take effect at the first rising clk edge after release; no pending flag write is retained.

Structure
REQ-028 A shared package SHALL hold the condition-code enumeration (EQ..AL, NV) and the flag bit index constants N_IDX=3, Z_IDX=2, C_IDX=1, V_IDX=0.
REQ-029 Condition evaluation SHALL be one purely combinational sub-module, condcheck (Cond, Flags -> CondEx); the flags register and strobe gating stay in cond_logic.

Verification
REQ-030 Reset low, Cond=0000 -> Flags=0000, CondEx=0, all strobes 0; release, Cond=1110, RegW=1 -> RegWrite=1.
REQ-031 Cond=1110, FlagW=11, ALUFlags=0100, En=1, one edge -> Flags=0100 next cycle; then Cond=0000 RegW=1 -> CondEx=1, RegWrite=1; Cond=0001 -> all strobes 0.
REQ-032 Flags=0100, FlagW=01, ALUFlags=1011 -> Flags=0111 (N,Z held, C,V loaded).
REQ-033 Flags=1000, Cond=1011 (LT) FlagW=11 ALUFlags=0000 -> CondEx=1, Flags=0000 after edge; same op with Cond=1010 -> CondEx=0, Flags stay 1000.
REQ-034 En=0, Cond=1110, FlagW=11, ALUFlags=1111, PCS=MemW=1 -> PCSrc=MemWrite=0, Flags unchanged after edge.
REQ-035 NoWrite=1, RegW=1, FlagW=11, Cond=1110, ALUFlags=0110 -> RegWrite=0, Flags=0110 next cycle; exhaustive sweep of 16 Cond x 16 Flags vs REQ-017 table.
